ram_dma_ci: RTL and testbench

- Custom-instruction (CI) accessible 512 x 32-bit scratch memory used as the CPU-side buffer of the DMA controller.
- The CPU issues a CI with `valueA` as the address/command word and `valueB` as write data.
- The block returns `result` with a one-cycle `done` strobe.
- The DMA controller reuses the same port: memory space is selected when `valueA[12:10]` = 000; other selector values belong to DMA registers and are not handled here.

---
 rtl/ram_dma_ci_if.sv | 19 +
 rtl/ram_dma_ci.sv | 50 +++++
 tb/tb_ram_dma_ci.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ram_dma_ci_if.sv
// rtl/ram_dma_ci_if.sv - custom-instruction port bundle between CPU and ram_dma_ci
interface ram_dma_ci_if;
  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic [31:0] result;
  logic        done;

  modport master (
    output start, ciN, valueA, valueB,
    input  result, done
  );

  modport slave (
    input  start, ciN, valueA, valueB,
    output result, done
  );
endinterface

// File: rtl/ram_dma_ci.sv
// rtl/ram_dma_ci.sv - 512 x 32 scratch RAM answering a custom instruction with 1-cycle done
module ram_dma_ci #(
  parameter logic [7:0] customId = 8'h00
) (
  input  logic          clock,
  input  logic          reset,
  ram_dma_ci_if.slave   bus
);

  logic [31:0] mem [0:511];
  logic [31:0] rd_data;
  logic [8:0]  addr;
  logic        accept;
  logic        mem_sel;
  logic        wr_en;
  logic        rd_en;
  logic        done_q;
  logic        rd_valid;
  logic [18:0] unused_cmd_bits;

  assign addr            = bus.valueA[8:0];
  assign accept          = bus.start && (bus.ciN == customId);
  assign mem_sel         = (bus.valueA[12:10] == 3'b000);
  assign wr_en           = accept && mem_sel && bus.valueA[9];
  assign rd_en           = accept && mem_sel && !bus.valueA[9];
  assign unused_cmd_bits = bus.valueA[31:13];

  // Storage has no reset so it maps onto a block RAM; the read returns pre-write contents.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[addr] <= bus.valueB;
    end
    rd_data <= mem[addr];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done_q   <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      done_q   <= accept;
      rd_valid <= rd_en;
    end
  end

  // rd_valid gating keeps result at zero for writes, foreign selectors and idle cycles.
  assign bus.done   = done_q;
  assign bus.result = rd_valid ? rd_data : 32'h0;

endmodule

// File: tb/tb_ram_dma_ci.sv
// tb/tb_ram_dma_ci.sv - directed self-checking bench for ram_dma_ci
module tb_ram_dma_ci;
  localparam logic [7:0] ID = 8'h00;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  ram_dma_ci_if bus ();

  ram_dma_ci #(.customId(ID)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one operation at the falling edge, then sample just after the accepting edge.
  task automatic ci_op(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op);
    @(negedge clock);
    bus.start  = 1'b1;
    bus.ciN    = op;
    bus.valueA = a;
    bus.valueB = b;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_check(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      bus.start  = 1'b0;
      bus.valueA = 32'h0000_0205;
      bus.valueB = 32'hFFFF_FFFF;
      @(posedge clock);
      #1;
      check_eq({tag, "_done"}, {31'h0, bus.done}, 32'h0);
      check_eq({tag, "_result"}, bus.result, 32'h0);
    end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.ciN    = ID;
    bus.valueA = 32'h0;
    bus.valueB = 32'h0;

    // Held in reset, even with start asserted
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      bus.start = (i >= 3);
      @(posedge clock);
      #1;
      check_eq("rst_done", {31'h0, bus.done}, 32'h0);
      check_eq("rst_result", bus.result, 32'h0);
    end
    @(negedge clock);
    bus.start = 1'b0;
    reset = 1'b1;
    idle_check("idle", 5);

    ci_op(32'h0000_0205, 32'hDEAD_BEEF, ID);
    check_eq("wr5_done", {31'h0, bus.done}, 32'h1);
    check_eq("wr5_result", bus.result, 32'h0);
    idle_check("after_wr5", 1);
    ci_op(32'h0000_0005, 32'h0, ID);
    check_eq("rd5_done", {31'h0, bus.done}, 32'h1);
    check_eq("rd5_result", bus.result, 32'hDEAD_BEEF);
    idle_check("after_rd5", 1);

    // Back-to-back completions across both address boundaries
    ci_op(32'h0000_03FF, 32'h1234_5678, ID);
    check_eq("wr1ff_done", {31'h0, bus.done}, 32'h1);
    check_eq("wr1ff_result", bus.result, 32'h0);
    ci_op(32'h0000_0200, 32'hA5A5_A5A5, ID);
    check_eq("wr000_done", {31'h0, bus.done}, 32'h1);
    ci_op(32'h0000_01FF, 32'h0, ID);
    check_eq("rd1ff_done", {31'h0, bus.done}, 32'h1);
    check_eq("rd1ff_result", bus.result, 32'h1234_5678);
    ci_op(32'h0000_0000, 32'h0, ID);
    check_eq("rd000_done", {31'h0, bus.done}, 32'h1);
    check_eq("rd000_result", bus.result, 32'hA5A5_A5A5);

    // Upper command bits are ignored
    ci_op(32'hFFFF_E005, 32'h0, ID);
    check_eq("rd_hi_result", bus.result, 32'hDEAD_BEEF);

    // Foreign opcode: ignored, including a write
    ci_op(32'h0000_0005, 32'h0, ID + 8'd1);
    check_eq("badci_rd_done", {31'h0, bus.done}, 32'h0);
    check_eq("badci_rd_result", bus.result, 32'h0);
    ci_op(32'h0000_0205, 32'h0BAD_0BAD, ID + 8'd1);
    check_eq("badci_wr_done", {31'h0, bus.done}, 32'h0);

    // Non-memory selector: done with zero result, no memory access
    ci_op(32'h0000_0405, 32'h0, ID);
    check_eq("sel1_rd_done", {31'h0, bus.done}, 32'h1);
    check_eq("sel1_rd_result", bus.result, 32'h0);
    ci_op(32'h0000_0605, 32'h1111_1111, ID);
    check_eq("sel1_wr_done", {31'h0, bus.done}, 32'h1);
    ci_op(32'h0000_0005, 32'h0, ID);
    check_eq("mem_kept_result", bus.result, 32'hDEAD_BEEF);

    // Read immediately after write to the same word
    ci_op(32'h0000_0210, 32'hCAFE_F00D, ID);
    ci_op(32'h0000_0010, 32'h0, ID);
    check_eq("raw_done", {31'h0, bus.done}, 32'h1);
    check_eq("raw_result", bus.result, 32'hCAFE_F00D);
    idle_check("after_raw", 1);

    // Asynchronous reset clears a live done immediately
    ci_op(32'h0000_0010, 32'h0, ID);
    check_eq("pre_rst_done", {31'h0, bus.done}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check_eq("async_rst_done", {31'h0, bus.done}, 32'h0);
    check_eq("async_rst_result", bus.result, 32'h0);
    @(negedge clock);
    bus.start = 1'b0;
    reset = 1'b1;
    idle_check("after_async", 1);

    // Read presented, reset asserted before its edge: no completion ever
    @(negedge clock);
    bus.start  = 1'b1;
    bus.ciN    = ID;
    bus.valueA = 32'h0000_0010;
    #2 reset = 1'b0;
    @(posedge clock);
    #1;
    check_eq("rst_drop_done", {31'h0, bus.done}, 32'h0);
    @(negedge clock);
    bus.start = 1'b0;
    reset = 1'b1;
    idle_check("rst_drop_after", 3);
    ci_op(32'h0000_0010, 32'h0, ID);
    check_eq("rst_reread_done", {31'h0, bus.done}, 32'h1);
    check_eq("rst_reread_result", bus.result, 32'hCAFE_F00D);
    idle_check("final", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
